// File: rtl/tlp_tx_mux.sv
// tlp_tx_mux
// Round-robin TLP transmit multiplexer. Each request channel owns a header
// FIFO (one 4DW header per entry) and a payload FIFO (one PAYLOAD_WIDTH word
// per entry), both show-ahead. The mux picks an eligible channel, emits the
// header as the first beat (header in the top 128 bits, zero below), then
// streams ceil(LEN*32/PAYLOAD_WIDTH) payload words from that channel. Once a
// channel is granted it is held until its last beat; no interleaving occurs.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   hdr_fifo_empty/data per-channel header FIFO status and head entry
//   hdr_fifo_rden       header pop (combinational, one-hot or zero)
//   pw_fifo_empty/data  per-channel payload FIFO status and head entry
//   pw_fifo_rden        payload pop (combinational, one-hot or zero)
//   tlp_out_valid/ready valid/ready handshake of the registered output beat
//   tlp_out_data/last   beat data and end-of-TLP flag
//   tlp_out_ch          channel that sourced the beat
module tlp_tx_mux #(
  parameter int PAYLOAD_WIDTH = 256,
  parameter int NUM_CH        = 2,
  parameter int HDR_WIDTH     = 128,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CH-1:0]                 hdr_fifo_empty,
  input  logic [NUM_CH*HDR_WIDTH-1:0]       hdr_fifo_data,
  output logic [NUM_CH-1:0]                 hdr_fifo_rden,
  input  logic [NUM_CH-1:0]                 pw_fifo_empty,
  input  logic [NUM_CH*PAYLOAD_WIDTH-1:0]   pw_fifo_data,
  output logic [NUM_CH-1:0]                 pw_fifo_rden,
  output logic                              tlp_out_valid,
  input  logic                              tlp_out_ready,
  output logic [PAYLOAD_WIDTH-1:0]          tlp_out_data,
  output logic                              tlp_out_last,
  output logic [CH_W-1:0]                   tlp_out_ch
);

  localparam int DW_PER_BEAT = PAYLOAD_WIDTH / 32;
  localparam int BEAT_SH     = $clog2(DW_PER_BEAT);
  localparam int HAS_DATA_B  = HDR_WIDTH - 2;   // hdr[126], fmt bit 1 of DW0
  localparam int LEN_MSB     = HDR_WIDTH - 23;  // hdr[105:96], DW0 length

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  state_t                     state, state_nxt;
  logic [CH_W-1:0]            rr_ptr, rr_nxt;
  logic [10:0]                cnt, cnt_nxt;

  logic [NUM_CH-1:0]          elig;
  logic                       found;
  logic [CH_W-1:0]            sel;
  logic [HDR_WIDTH-1:0]       sel_hdr;
  logic                       g_pw_empty;
  logic [PAYLOAD_WIDTH-1:0]   g_pw_data;
  logic                       load;
  logic                       beat_vld;
  logic [PAYLOAD_WIDTH-1:0]   beat_data;
  logic                       beat_last;
  logic [CH_W-1:0]            beat_ch;

  // Payload beats for a header; LEN of zero encodes 1024 DW.
  function automatic logic [10:0] beat_count(input logic [HDR_WIDTH-1:0] hdr);
    logic [10:0] len_dw;
    len_dw = (hdr[LEN_MSB -: 10] == 10'd0) ? 11'd1024 : {1'b0, hdr[LEN_MSB -: 10]};
    return (len_dw + 11'(DW_PER_BEAT - 1)) >> BEAT_SH;
  endfunction

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    return (c == CH_W'(NUM_CH - 1)) ? '0 : c + 1'b1;
  endfunction

  // A header can only go out when its payload is already available, so a
  // granted write never starts with an empty payload FIFO.
  always_comb begin
    elig = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      elig[c] = !hdr_fifo_empty[c] &&
                (!hdr_fifo_data[c*HDR_WIDTH + HAS_DATA_B] || !pw_fifo_empty[c]);
    end
  end

  // Round-robin search: rotate the eligible vector so bit 0 is rr_ptr, then
  // take the lowest set bit (scanning downward so the lowest index wins).
  always_comb begin : p_arb
    logic [2*NUM_CH-1:0] rot;
    int                  s;
    rot   = {elig, elig} >> rr_ptr;
    found = 1'b0;
    sel   = '0;
    s     = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        s     = int'(rr_ptr) + i;
        if (s >= NUM_CH) s = s - NUM_CH;
        sel   = CH_W'(s);
      end
    end
  end

  always_comb begin
    sel_hdr    = '0;
    g_pw_empty = 1'b1;
    g_pw_data  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (CH_W'(c) == sel) sel_hdr = hdr_fifo_data[c*HDR_WIDTH +: HDR_WIDTH];
      if (CH_W'(c) == tlp_out_ch) begin
        g_pw_empty = pw_fifo_empty[c];
        g_pw_data  = pw_fifo_data[c*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
      end
    end
  end

  // The output register may take a new beat when it is empty or its current
  // beat is leaving this cycle; this gives back-to-back TLPs at full rate.
  assign load = !tlp_out_valid || tlp_out_ready;

  // tlp_out_ch doubles as the locked grant while a TLP is in flight.
  // rr_ptr advances when the last beat is committed to the output register;
  // since a TLP is never aborted, that beat is guaranteed to transfer.
  always_comb begin
    state_nxt     = state;
    rr_nxt        = rr_ptr;
    cnt_nxt       = cnt;
    hdr_fifo_rden = '0;
    pw_fifo_rden  = '0;
    beat_vld      = 1'b0;
    beat_data     = tlp_out_data;
    beat_last     = tlp_out_last;
    beat_ch       = tlp_out_ch;
    case (state)
      IDLE: begin
        // rst_n gate keeps the pops quiet while reset is held.
        if (rst_n && load && found) begin
          hdr_fifo_rden                           = NUM_CH'(1) << sel;
          beat_vld                                = 1'b1;
          beat_data                               = '0;
          beat_data[PAYLOAD_WIDTH-1 -: HDR_WIDTH] = sel_hdr;
          beat_last                               = !sel_hdr[HAS_DATA_B];
          beat_ch                                 = sel;
          if (sel_hdr[HAS_DATA_B]) begin
            cnt_nxt   = beat_count(sel_hdr);
            state_nxt = HDR;
          end else begin
            cnt_nxt   = '0;
            rr_nxt    = next_ch(sel);
          end
        end
      end
      HDR, PAY: begin
        // An empty payload FIFO simply stalls here with the grant held.
        if (load && !g_pw_empty) begin
          pw_fifo_rden = NUM_CH'(1) << tlp_out_ch;
          beat_vld     = 1'b1;
          beat_data    = g_pw_data;
          beat_last    = (cnt == 11'd1);
          beat_ch      = tlp_out_ch;
          cnt_nxt      = cnt - 11'd1;
          if (cnt == 11'd1) begin
            state_nxt = IDLE;
            rr_nxt    = next_ch(tlp_out_ch);
          end else begin
            state_nxt = PAY;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cnt           <= '0;
      tlp_out_valid <= 1'b0;
      tlp_out_data  <= '0;
      tlp_out_last  <= 1'b0;
      tlp_out_ch    <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
      cnt    <= cnt_nxt;
      if (load) begin
        tlp_out_valid <= beat_vld;
        if (beat_vld) begin
          tlp_out_data <= beat_data;
          tlp_out_last <= beat_last;
          tlp_out_ch   <= beat_ch;
        end
      end
    end
  end

endmodule

// File: tb/tb_tlp_tx_mux.sv
// tb_tlp_tx_mux
// Bench for tlp_tx_mux (PAYLOAD_WIDTH=256, NUM_CH=2). Header and payload
// FIFOs are modelled as show-ahead memories with read/write pointers; the
// DUT's rden strobes advance the read pointers on the clock edge.
module tb_tlp_tx_mux;
  localparam int W   = 256;
  localparam int NCH = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NCH-1:0]     hdr_fifo_empty;
  logic [NCH*128-1:0] hdr_fifo_data;
  logic [NCH-1:0]     hdr_fifo_rden;
  logic [NCH-1:0]     pw_fifo_empty;
  logic [NCH*W-1:0]   pw_fifo_data;
  logic [NCH-1:0]     pw_fifo_rden;
  logic               tlp_out_valid;
  logic               tlp_out_ready;
  logic [W-1:0]       tlp_out_data;
  logic               tlp_out_last;
  logic [0:0]         tlp_out_ch;

  always #5 clk = ~clk;

  tlp_tx_mux #(.PAYLOAD_WIDTH(W), .NUM_CH(NCH)) dut (
    .clk(clk), .rst_n(rst_n),
    .hdr_fifo_empty(hdr_fifo_empty), .hdr_fifo_data(hdr_fifo_data),
    .hdr_fifo_rden(hdr_fifo_rden),
    .pw_fifo_empty(pw_fifo_empty), .pw_fifo_data(pw_fifo_data),
    .pw_fifo_rden(pw_fifo_rden),
    .tlp_out_valid(tlp_out_valid), .tlp_out_ready(tlp_out_ready),
    .tlp_out_data(tlp_out_data), .tlp_out_last(tlp_out_last),
    .tlp_out_ch(tlp_out_ch)
  );

  // FIFO models
  logic [127:0]   hmem [NCH][512];
  logic [W-1:0]   pmem [NCH][512];
  logic [8:0]     hwp [NCH] = '{default: '0};
  logic [8:0]     pwp [NCH] = '{default: '0};
  logic [8:0]     hrp [NCH] = '{default: '0};
  logic [8:0]     prp [NCH] = '{default: '0};
  logic [NCH-1:0] hold = '0;
  int             popfail = 0;

  for (genvar c = 0; c < NCH; c++) begin : g_fifo
    assign hdr_fifo_empty[c]          = (hwp[c] == hrp[c]);
    assign hdr_fifo_data[c*128 +: 128] = hmem[c][hrp[c]];
    assign pw_fifo_empty[c]           = (pwp[c] == prp[c]) || hold[c];
    assign pw_fifo_data[c*W +: W]     = pmem[c][prp[c]];
  end

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (!rst_n) begin
        hrp[c] <= hwp[c];
        prp[c] <= pwp[c];
      end else begin
        if (hdr_fifo_rden[c]) begin
          if (hdr_fifo_empty[c]) popfail <= popfail + 1;
          hrp[c] <= hrp[c] + 9'd1;
        end
        if (pw_fifo_rden[c]) begin
          if (pw_fifo_empty[c]) popfail <= popfail + 1;
          prp[c] <= prp[c] + 9'd1;
        end
      end
    end
  end

  task automatic push_h(input int c, input logic [127:0] h);
    hmem[c][hwp[c]] = h;
    hwp[c] = hwp[c] + 9'd1;
  endtask

  task automatic push_p(input int c, input logic [W-1:0] p);
    pmem[c][pwp[c]] = p;
    pwp[c] = pwp[c] + 9'd1;
  endtask

  function automatic logic [W-1:0] hb(input logic [127:0] h);
    return {h, 128'h0};
  endfunction

  function automatic logic [W-1:0] pword(input int k);
    return {8{32'hC000_0000 + 32'(k)}};
  endfunction

  // Checking
  int ntot = 0;
  int npass = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
  endtask

  typedef struct {
    logic         ready;
    logic         valid;
    logic         last;
    logic         ch;
    logic [W-1:0] data;
    logic [1:0]   hrd;
    logic [1:0]   prd;
  } vec_t;

  vec_t tbl [32];
  int   ntbl = 0;

  task automatic add(input logic rdy, input logic v, input logic l, input logic ch,
                     input logic [W-1:0] d, input logic [1:0] hr, input logic [1:0] pr);
    tbl[ntbl] = '{ready: rdy, valid: v, last: l, ch: ch, data: d, hrd: hr, prd: pr};
    ntbl++;
  endtask

  task automatic apply(input int lo, input int hi, input string nm);
    for (int i = lo; i <= hi; i++) begin
      tlp_out_ready = tbl[i].ready;
      #1;
      chk($sformatf("%s[%0d].valid", nm, i-lo), W'(tlp_out_valid), W'(tbl[i].valid));
      if (tbl[i].valid) begin
        chk($sformatf("%s[%0d].data", nm, i-lo), tlp_out_data, tbl[i].data);
        chk($sformatf("%s[%0d].last", nm, i-lo), W'(tlp_out_last), W'(tbl[i].last));
        chk($sformatf("%s[%0d].ch", nm, i-lo), W'(tlp_out_ch), W'(tbl[i].ch));
      end
      chk($sformatf("%s[%0d].hdr_rden", nm, i-lo), W'(hdr_fifo_rden), W'(tbl[i].hrd));
      chk($sformatf("%s[%0d].pw_rden", nm, i-lo), W'(pw_fifo_rden), W'(tbl[i].prd));
      @(negedge clk);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, ".valid"}, W'(tlp_out_valid), '0);
    chk({nm, ".data"}, tlp_out_data, '0);
    chk({nm, ".last"}, W'(tlp_out_last), '0);
    chk({nm, ".ch"}, W'(tlp_out_ch), '0);
    chk({nm, ".hdr_rden"}, W'(hdr_fifo_rden), '0);
    chk({nm, ".pw_rden"}, W'(pw_fifo_rden), '0);
  endtask

  task automatic do_reset(input bit check);
    rst_n = 1'b0;
    hold  = '0;
    #1;
    if (check) check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [127:0] HA  = {32'h6000_0010, 32'h0000_00FF, 32'h1234_5678, 32'h9ABC_DEF0};
  localparam logic [127:0] M0A = {32'h2000_0001, 32'h0000_0A0F, 32'h0000_0000, 32'hA000_0000};
  localparam logic [127:0] M0B = {32'h2000_0001, 32'h0000_0B0F, 32'h0000_0000, 32'hB000_0000};
  localparam logic [127:0] M1A = {32'h2000_0001, 32'h0001_0A0F, 32'h0000_0000, 32'hA100_0000};
  localparam logic [127:0] MC  = {32'h2000_0002, 32'h0000_0C0F, 32'h0000_0000, 32'hC000_0000};
  localparam logic [127:0] MC2 = {32'h2000_0003, 32'h0000_0D0F, 32'h0000_0000, 32'hC200_0000};
  localparam logic [127:0] HD  = {32'h6000_0000, 32'h0000_00FF, 32'h0000_0000, 32'hD000_0000};
  localparam logic [127:0] HE  = {32'h6000_0010, 32'h0000_00EE, 32'h0000_0000, 32'hE000_0000};
  localparam logic [127:0] R1  = {32'h2000_0001, 32'h0001_0E0F, 32'h0000_0000, 32'hE100_0000};
  localparam logic [127:0] HF  = {32'h6000_0010, 32'h0000_00AA, 32'h0000_0000, 32'hF000_0000};
  localparam logic [127:0] XF  = {32'h2000_0001, 32'h0000_0F0F, 32'h0000_0000, 32'hF100_0000};
  localparam logic [127:0] HG  = {32'h2000_0001, 32'h0001_0F0F, 32'h0000_0000, 32'hF200_0000};
  localparam logic [W-1:0] P0  = {8{32'h1111_0000}};
  localparam logic [W-1:0] P1  = {8{32'h2222_0001}};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nb, nlast, lastpos, derr;
    logic hdr_ok;

    // MWr LEN=16 on ch0: header, payload, payload+last
    add(1, 0, 0, 0, '0,      2'b01, 2'b00);
    add(1, 1, 0, 0, hb(HA),  2'b00, 2'b01);
    add(1, 1, 0, 0, P0,      2'b00, 2'b01);
    add(1, 1, 1, 0, P1,      2'b00, 2'b00);
    add(1, 0, 0, 0, '0,      2'b00, 2'b00);
    // MRd on both channels: round robin ch0, ch1, ch0
    add(1, 0, 0, 0, '0,      2'b01, 2'b00);
    add(1, 1, 1, 0, hb(M0A), 2'b10, 2'b00);
    add(1, 1, 1, 1, hb(M1A), 2'b01, 2'b00);
    add(1, 1, 1, 0, hb(M0B), 2'b00, 2'b00);
    add(1, 0, 0, 0, '0,      2'b00, 2'b00);
    // ready held low 5 cycles on a header beat
    add(0, 0, 0, 0, '0,      2'b01, 2'b00);
    for (int k = 0; k < 5; k++) add(0, 1, 1, 0, hb(MC), 2'b00, 2'b00);
    add(1, 1, 1, 0, hb(MC),  2'b01, 2'b00);
    add(1, 1, 1, 0, hb(MC2), 2'b00, 2'b00);
    add(1, 0, 0, 0, '0,      2'b00, 2'b00);

    tlp_out_ready = 1'b1;
    do_reset(1'b1);

    push_h(0, HA); push_p(0, P0); push_p(0, P1);
    apply(0, 4, "mwr16");

    do_reset(1'b0);
    push_h(0, M0A); push_h(0, M0B); push_h(1, M1A);
    apply(5, 9, "mrd_rr");

    push_h(0, MC); push_h(0, MC2);
    apply(10, 18, "hold_ready");

    // LEN=0: 1 header + 128 payload beats, one extra word left in the FIFO
    push_h(0, HD);
    for (int k = 0; k < 129; k++) push_p(0, pword(k));
    nb = 0; nlast = 0; lastpos = 0; derr = 0; hdr_ok = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      #1;
      if (tlp_out_valid) begin
        nb++;
        if (nb == 1) hdr_ok = (tlp_out_data === hb(HD)) && (tlp_out_ch == 1'b0);
        else if ((tlp_out_data !== pword(nb - 2)) || (tlp_out_ch != 1'b0)) derr++;
        if (tlp_out_last) begin
          nlast++;
          lastpos = nb;
        end
      end
      @(negedge clk);
    end
    chk("len0.beats", W'(nb), W'(129));
    chk("len0.last_count", W'(nlast), W'(1));
    chk("len0.last_pos", W'(lastpos), W'(129));
    chk("len0.payload_errors", W'(derr), '0);
    chk("len0.header", W'(hdr_ok), W'(1));
    chk("len0.leftover_words", W'(pwp[0] - prp[0]), W'(1));

    // payload FIFO goes empty mid-TLP for 3 cycles; ch1 waits
    do_reset(1'b0);
    push_h(0, HE); push_p(0, P0); push_p(0, P1); push_h(1, R1);
    #1;
    chk("stall.first_grant", W'(hdr_fifo_rden), W'(2'b01));
    tick();
    chk("stall.hdr_valid", W'(tlp_out_valid), W'(1));
    chk("stall.hdr_data", tlp_out_data, hb(HE));
    tick();
    chk("stall.p0_data", tlp_out_data, P0);
    chk("stall.p0_last", W'(tlp_out_last), '0);
    hold[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall.gap%0d.valid", k), W'(tlp_out_valid), '0);
      chk($sformatf("stall.gap%0d.hdr_rden", k), W'(hdr_fifo_rden), '0);
      chk($sformatf("stall.gap%0d.pw_rden", k), W'(pw_fifo_rden), '0);
    end
    hold[0] = 1'b0;
    tick();
    chk("stall.p1_valid", W'(tlp_out_valid), W'(1));
    chk("stall.p1_data", tlp_out_data, P1);
    chk("stall.p1_last", W'(tlp_out_last), W'(1));
    chk("stall.p1_ch", W'(tlp_out_ch), '0);
    tick();
    chk("stall.ch1_valid", W'(tlp_out_valid), W'(1));
    chk("stall.ch1_data", tlp_out_data, hb(R1));
    chk("stall.ch1_ch", W'(tlp_out_ch), W'(1));
    chk("stall.ch1_last", W'(tlp_out_last), W'(1));
    @(negedge clk);

    // reset asserted while a payload beat is on the output
    push_h(0, HF); push_p(0, P0); push_p(0, P1); push_h(0, XF);
    tick();
    chk("midrst.hdr_data", tlp_out_data, hb(HF));
    tick();
    chk("midrst.p0_valid", W'(tlp_out_valid), W'(1));
    chk("midrst.p0_data", tlp_out_data, P0);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_h(1, HG);
    tick();
    chk("midrst.after_valid", W'(tlp_out_valid), W'(1));
    chk("midrst.after_data", tlp_out_data, hb(HG));
    chk("midrst.after_ch", W'(tlp_out_ch), W'(1));
    chk("midrst.after_last", W'(tlp_out_last), W'(1));
    @(negedge clk);

    chk("no_pop_of_empty", W'(popfail), '0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
